// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the RV32M multiply/divide unit.
// Used by muldiv_unit and muldiv_sign_fix (optional MULDIV_FAST_MUL_EN lives in the top).
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes at accept time, and
// negate/select of the unsigned product or quotient/remainder at result time.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_e         i_op,
  input  logic [XLEN-1:0]    i_val_a,
  input  logic [XLEN-1:0]    i_val_b,
  output logic [XLEN-1:0]    o_abs_a,
  output logic [XLEN-1:0]    o_abs_b,
  output logic               o_neg_q,
  output logic               o_neg_r,
  input  muldiv_op_e         i_res_op,
  input  logic [2*XLEN-1:0]  i_acc,
  input  logic               i_res_neg_q,
  input  logic               i_res_neg_r,
  output logic [XLEN-1:0]    o_result
);

  logic              w_sa;
  logic              w_sb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  always_comb begin
    w_sa    = is_signed_a(i_op) & i_val_a[XLEN-1];
    w_sb    = is_signed_b(i_op) & i_val_b[XLEN-1];
    o_abs_a = w_sa ? -i_val_a : i_val_a;
    o_abs_b = w_sb ? -i_val_b : i_val_b;
    o_neg_q = w_sa ^ w_sb;
    o_neg_r = w_sa;
  end

  // Accumulator holds {hi, lo}: product for mul, {remainder, quotient} for div.
  always_comb begin
    w_prod   = i_res_neg_q ? -i_acc : i_acc;
    w_quot   = i_res_neg_q ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
    w_rem    = i_res_neg_r ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
    o_result = '0;
    case (i_res_op)
      OP_MUL:                       o_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              o_result = w_quot;
      OP_REM, OP_REMU:              o_result = w_rem;
      default:                      o_result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
// Define MULDIV_FAST_MUL_EN to compute MUL* ops in a single cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] valA,
  input  logic [XLEN-1:0] valB,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e   r_state;
  muldiv_state_e   w_state_nxt;
  muldiv_op_e      r_op;
  muldiv_op_e      w_op_in;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc_hi;
  logic [XLEN-1:0] r_acc_lo;
  logic [XLEN-1:0] r_b;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_accept;
  logic            w_div_in;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_short;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_neg_q;
  logic            w_neg_r;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_result;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
`endif

  assign w_op_in  = muldiv_op_e'(funct3);
  assign w_accept = in_valid && (r_state == S_IDLE) && !kill;
  assign w_div_in = is_div(w_op_in);
  assign w_b_zero = (valB == '0);
  assign w_ovf    = w_div_in && is_signed_a(w_op_in) &&
                    (valA == {1'b1, {(XLEN-1){1'b0}}}) && (valB == '1);
`ifdef MULDIV_FAST_MUL_EN
  assign w_short  = !w_div_in || (w_div_in && (w_b_zero || w_ovf));
`else
  assign w_short  = w_div_in && (w_b_zero || w_ovf);
`endif

  // Shift-add multiply and restoring-divide steps share the {hi, lo} accumulator.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_trial   = {r_acc_hi, r_acc_lo[XLEN-1]} - {1'b0, r_b};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_op        (w_op_in),
    .i_val_a     (valA),
    .i_val_b     (valB),
    .o_abs_a     (w_abs_a),
    .o_abs_b     (w_abs_b),
    .o_neg_q     (w_neg_q),
    .o_neg_r     (w_neg_r),
    .i_res_op    (r_op),
    .i_acc       ({r_acc_hi, r_acc_lo}),
    .i_res_neg_q (r_neg_q),
    .i_res_neg_r (r_neg_r),
    .o_result    (w_result)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_short ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op     <= OP_MUL;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_op  <= w_op_in;
      r_rd  <= rd_in;
      r_cnt <= CW'(XLEN-1);
      r_b   <= w_abs_b;
      // Special cases preload the accumulator so the normal result path yields the answer unmodified.
      if (w_div_in && w_b_zero) begin
        r_acc_hi <= valA;
        r_acc_lo <= '1;
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
      end else if (w_ovf) begin
        r_acc_hi <= '0;
        r_acc_lo <= valA;
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      end else if (!w_div_in) begin
        {r_acc_hi, r_acc_lo} <= w_fast_prod;
        r_neg_q  <= w_neg_q;
        r_neg_r  <= w_neg_r;
`endif
      end else begin
        r_acc_hi <= '0;
        r_acc_lo <= w_abs_a;
        r_neg_q  <= w_neg_q;
        r_neg_r  <= w_neg_r;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      if (!is_div(r_op)) begin
        r_acc_hi <= w_mul_sum[XLEN:1];
        r_acc_lo <= {w_mul_sum[0], r_acc_lo[XLEN-1:1]};
      end else if (!w_trial[XLEN]) begin
        r_acc_hi <= w_trial[XLEN-1:0];
        r_acc_lo <= {r_acc_lo[XLEN-2:0], 1'b1};
      end else begin
        r_acc_hi <= {r_acc_hi[XLEN-2:0], r_acc_lo[XLEN-1]};
        r_acc_lo <= {r_acc_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = out_valid ? w_result : '0;
  assign rd_out    = r_rd;

endmodule
